// File: rtl/get_reg.sv
// get_reg: registered RISC-V register-index to ASCII name lookup, three channels, latency 1.
// Define GETREG_NUMERIC_EN to emit architectural names "x0".."x31" instead of ABI names.
module get_reg #(
    parameter int NAME_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [4:0]        rd_idx,
    input  logic [4:0]        rs1_idx,
    input  logic [4:0]        rs2_idx,
    output logic              out_valid,
    output logic [NAME_W-1:0] rd_name,
    output logic [NAME_W-1:0] rs1_name,
    output logic [NAME_W-1:0] rs2_name,
    output logic [2:0]        rd_len,
    output logic [2:0]        rs1_len,
    output logic [2:0]        rs2_len
);

    localparam int NCH = 3;

    typedef struct packed {
        logic [2:0]  len;
        logic [31:0] name;
    } name_t;

    // Digit bytes are built arithmetically; names are right-justified, upper bytes zero.
    function automatic name_t lookup(input logic [4:0] idx);
        name_t      r;
        logic [7:0] i8;
        i8     = {3'b000, idx};
        r.name = '0;
        r.len  = 3'd2;
`ifdef GETREG_NUMERIC_EN
        if (idx < 5'd10) begin
            r.name[15:0] = {"x", 8'h30 + i8};
        end else if (idx < 5'd20) begin
            r.name[23:0] = {"x1", 8'h30 + i8 - 8'd10};
            r.len        = 3'd3;
        end else if (idx < 5'd30) begin
            r.name[23:0] = {"x2", 8'h30 + i8 - 8'd20};
            r.len        = 3'd3;
        end else begin
            r.name[23:0] = {"x3", 8'h30 + i8 - 8'd30};
            r.len        = 3'd3;
        end
`else
        case (idx) inside
            5'd0:           begin r.name = "zero"; r.len = 3'd4; end
            5'd1:           r.name[15:0] = "ra";
            5'd2:           r.name[15:0] = "sp";
            5'd3:           r.name[15:0] = "gp";
            5'd4:           r.name[15:0] = "tp";
            [5'd5:5'd7]:    r.name[15:0] = {"t", 8'h30 + i8 - 8'd5};
            [5'd8:5'd9]:    r.name[15:0] = {"s", 8'h30 + i8 - 8'd8};
            [5'd10:5'd17]:  r.name[15:0] = {"a", 8'h30 + i8 - 8'd10};
            [5'd18:5'd25]:  r.name[15:0] = {"s", 8'h30 + i8 - 8'd16};
            [5'd26:5'd27]:  begin r.name[23:0] = {"s1", 8'h30 + i8 - 8'd26}; r.len = 3'd3; end
            default:        r.name[15:0] = {"t", 8'h30 + i8 - 8'd25};
        endcase
`endif
        return r;
    endfunction

    logic [NCH-1:0][4:0]        w_idx;
    name_t [NCH-1:0]            w_lk;
    logic                       r_valid;
    logic [NCH-1:0][NAME_W-1:0] r_name;
    logic [NCH-1:0][2:0]        r_len;

    assign w_idx = {rs2_idx, rs1_idx, rd_idx};

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign w_lk[c] = lookup(w_idx[c]);

        always_ff @(posedge clk) begin
            if (reset) begin
                r_name[c] <= '0;
                r_len[c]  <= '0;
            end else if (in_valid) begin
                r_name[c] <= NAME_W'(w_lk[c].name);
                r_len[c]  <= w_lk[c].len;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_valid <= 1'b0;
        else       r_valid <= in_valid;
    end

    assign out_valid = r_valid;
    assign rd_name   = r_name[0];
    assign rs1_name  = r_name[1];
    assign rs2_name  = r_name[2];
    assign rd_len    = r_len[0];
    assign rs1_len   = r_len[1];
    assign rs2_len   = r_len[2];

endmodule

// File: tb/tb_get_reg.sv
// Directed bench for get_reg: reset, spec vectors, full sweep, hold, mid-stream reset.
module tb_get_reg;

    logic        clk = 1'b0;
    logic        reset, in_valid;
    logic [4:0]  rd_idx, rs1_idx, rs2_idx;
    logic        out_valid;
    logic [31:0] rd_name, rs1_name, rs2_name;
    logic [2:0]  rd_len, rs1_len, rs2_len;

    int total = 0;
    int bad   = 0;

    string abi [32] = '{"zero","ra","sp","gp","tp","t0","t1","t2","s0","s1",
                        "a0","a1","a2","a3","a4","a5","a6","a7",
                        "s2","s3","s4","s5","s6","s7","s8","s9","s10","s11",
                        "t3","t4","t5","t6"};

    get_reg #(.NAME_W(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .rd_idx(rd_idx), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
        .out_valid(out_valid),
        .rd_name(rd_name), .rs1_name(rs1_name), .rs2_name(rs2_name),
        .rd_len(rd_len), .rs1_len(rs1_len), .rs2_len(rs2_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic string ref_str(input int i);
`ifdef GETREG_NUMERIC_EN
        return $sformatf("x%0d", i);
`else
        return abi[i];
`endif
    endfunction

    function automatic logic [31:0] ref_name(input int i);
        string       s;
        logic [31:0] v;
        s = ref_str(i);
        v = '0;
        for (int k = 0; k < s.len(); k++) v = {v[23:0], s[k]};
        return v;
    endfunction

    function automatic logic [2:0] ref_len(input int i);
        string s;
        s = ref_str(i);
        return 3'(s.len());
    endfunction

    task automatic chk_ch(input string tag, input logic [31:0] nm, input logic [2:0] ln, input int i);
        chk({tag, "_name"}, 64'(nm), 64'(ref_name(i)));
        chk({tag, "_len"},  64'(ln), 64'(ref_len(i)));
    endtask

    task automatic chk_all(input string tag, input logic ev, input int a, input int b, input int c);
        chk({tag, "_valid"}, 64'(out_valid), 64'(ev));
        chk_ch({tag, "_rd"},  rd_name,  rd_len,  a);
        chk_ch({tag, "_rs1"}, rs1_name, rs1_len, b);
        chk_ch({tag, "_rs2"}, rs2_name, rs2_len, c);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_names"}, {rd_name, rs1_name}, 64'd0);
        chk({tag, "_rs2"}, 64'(rs2_name), 64'd0);
        chk({tag, "_lens"}, 64'({rd_len, rs1_len, rs2_len}), 64'd0);
    endtask

    task automatic drive(input logic v, input int a, input int b, input int c);
        in_valid = v;
        rd_idx   = 5'(a);
        rs1_idx  = 5'(b);
        rs2_idx  = 5'(c);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        // Reset dominates an asserted in_valid
        drive(1'b1, 0, 1, 2);
        chk_zero("rst0");
        drive(1'b1, 3, 4, 5);
        chk_zero("rst1");
        reset = 1'b0;

        drive(1'b1, 0, 1, 2);
        chk_all("v012", 1'b1, 0, 1, 2);
`ifdef GETREG_NUMERIC_EN
        chk("num_x0", 64'(rd_name), 64'h0000_7830);
        chk("num_x0_len", 64'(rd_len), 64'd2);
        drive(1'b1, 17, 5, 31);
        chk("num_x17", 64'(rd_name), 64'h0078_3137);
        chk("num_x17_len", 64'(rd_len), 64'd3);
        chk("num_x5", 64'(rs1_name), 64'h0000_7835);
        chk("num_x31", 64'(rs2_name), 64'h0078_3331);
`else
        chk("zero", 64'(rd_name), 64'h7A65_726F);
        chk("zero_len", 64'(rd_len), 64'd4);
        chk("ra", 64'(rs1_name), 64'h0000_7261);
        chk("sp", 64'(rs2_name), 64'h0000_7370);
        drive(1'b1, 8, 26, 31);
        chk("s0", 64'(rd_name), 64'h0000_7330);
        chk("s10", 64'(rs1_name), 64'h0073_3130);
        chk("s10_len", 64'(rs1_len), 64'd3);
        chk("t6", 64'(rs2_name), 64'h0000_7436);
`endif

        // Back-to-back sweep, different index per channel
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, i, 31 - i, (i + 7) % 32);
            chk_all($sformatf("sweep%0d", i), 1'b1, i, 31 - i, (i + 7) % 32);
        end

        drive(1'b1, 9, 9, 9);
        chk_all("same", 1'b1, 9, 9, 9);

        // Single pulse, then idle with changing indices: names must hold
        drive(1'b1, 5, 9, 28);
        chk_all("pulse", 1'b1, 5, 9, 28);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, k, k + 10, k + 20);
            chk_all($sformatf("hold%0d", k), 1'b0, 5, 9, 28);
        end

        drive(1'b1, 27, 18, 4);
        chk_all("resume", 1'b1, 27, 18, 4);
        reset = 1'b1;
        drive(1'b1, 1, 2, 3);
        chk_zero("midrst");
        reset = 1'b0;
        drive(1'b1, 30, 0, 13);
        chk_all("after", 1'b1, 30, 0, 13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
